// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 single-wire sensor controller:
// FSM state encoding, failure codes, default timing and the frame checksum.
package dht11_pkg;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      START_LOW = 4'd1,
      WAIT_RESP = 4'd2,
      RESP_LOW  = 4'd3,
      RESP_HIGH = 4'd4,
      BIT_LOW   = 4'd5,
      BIT_HIGH  = 4'd6,
      CHECK     = 4'd7,
      DONE      = 4'd8
   } dht_state_e;

   localparam logic [1:0] ERR_NONE        = 2'b00;
   localparam logic [1:0] ERR_NO_RESP     = 2'b01;
   localparam logic [1:0] ERR_BIT_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_CHECKSUM    = 2'b11;

   localparam int DEF_START_LOW_CYC  = 18000;
   localparam int DEF_TIMEOUT_CYC    = 200;
   localparam int DEF_BIT_THRESH_CYC = 48;

   localparam int CNT_W      = 15;
   localparam int FRAME_BITS = 40;

   // Byte 0 is the first byte on the wire and sits in the top of the frame.
   function automatic logic checksum_ok(input logic [39:0] frame);
      logic [7:0] sum;
      sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
      return (sum == frame[7:0]);
   endfunction

endpackage

// File: rtl/dht11_sync.sv
// Two-flop synchronizer for the asynchronous sensor line plus rise/fall strobes.
// All flops reset to 1, matching the idle (pulled-up) line.
module dht11_sync (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Synchronizer chain and one-cycle history for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise_o = sync_q & ~prev_q;
   assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/dht11_controller.sv
// DHT11 read controller: issues the host start pulse, times the sensor response
// and 40 data bits, verifies the checksum and presents the humidity/temperature bytes.
module dht11_controller
   import dht11_pkg::*;
#(
   parameter int START_LOW_CYC  = DEF_START_LOW_CYC,
   parameter int TIMEOUT_CYC    = DEF_TIMEOUT_CYC,
   parameter int BIT_THRESH_CYC = DEF_BIT_THRESH_CYC
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       dht_in,
   output logic       dht_oe,
   output logic       busy,
   output logic       valid,
   output logic [7:0] hum_int,
   output logic [7:0] hum_dec,
   output logic [7:0] temp_int,
   output logic [7:0] temp_dec,
   output logic       error,
   output logic [1:0] err_code
);

   localparam int START_LAST_I = START_LOW_CYC - 1;
   localparam int TO_LAST_I    = TIMEOUT_CYC - 1;
   localparam int THRESH_M1_I  = BIT_THRESH_CYC - 1;
   localparam logic [CNT_W-1:0] START_LAST = START_LAST_I[CNT_W-1:0];
   localparam logic [CNT_W-1:0] TO_LAST    = TO_LAST_I[CNT_W-1:0];
   localparam logic [CNT_W-1:0] TO_SAT     = TIMEOUT_CYC[CNT_W-1:0];
   localparam logic [CNT_W-1:0] THRESH_M1  = THRESH_M1_I[CNT_W-1:0];
   localparam logic [5:0]       LAST_BIT   = 6'(FRAME_BITS - 1);

   dht_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [5:0]  idx_q, idx_d;
   logic [39:0] shift_q, shift_d;
   logic        dht_oe_q, dht_oe_d;
   logic        busy_q, busy_d;
   logic        valid_q, valid_d;
   logic        error_q, error_d;
   logic [1:0]  err_code_q, err_code_d;
   logic [7:0]  hum_int_q, hum_int_d, hum_dec_q, hum_dec_d;
   logic [7:0]  temp_int_q, temp_int_d, temp_dec_q, temp_dec_d;
   logic        rise_s, fall_s, timeout_s;

   dht11_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .d_i    (dht_in),
      .rise_o (rise_s),
      .fall_o (fall_s)
   );

   // Next-state, datapath and output decode; edges are tested before timeouts
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      err_code_d = err_code_q;
      valid_d    = 1'b0;
      error_d    = 1'b0;
      hum_int_d  = hum_int_q;
      hum_dec_d  = hum_dec_q;
      temp_int_d = temp_int_q;
      temp_dec_d = temp_dec_q;
      timeout_s  = (cnt_q >= TO_LAST);

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = START_LOW;
               idx_d   = 6'd0;
               shift_d = 40'd0;
            end else begin
               state_d = IDLE;
            end
         end
         START_LOW: begin
            if (cnt_q >= START_LAST) state_d = WAIT_RESP;
            else                     state_d = START_LOW;
         end
         WAIT_RESP, RESP_LOW, RESP_HIGH: begin
            if ((state_q == WAIT_RESP) && fall_s) begin
               state_d = RESP_LOW;
            end else if ((state_q == RESP_LOW) && rise_s) begin
               state_d = RESP_HIGH;
            end else if ((state_q == RESP_HIGH) && fall_s) begin
               state_d = BIT_LOW;
            end else if (timeout_s) begin
               state_d    = DONE;
               error_d    = 1'b1;
               err_code_d = ERR_NO_RESP;
            end else begin
               state_d = state_q;
            end
         end
         BIT_LOW: begin
            if (rise_s) begin
               state_d = BIT_HIGH;
            end else if (timeout_s) begin
               state_d    = DONE;
               error_d    = 1'b1;
               err_code_d = ERR_BIT_TIMEOUT;
            end else begin
               state_d = BIT_LOW;
            end
         end
         BIT_HIGH: begin
            // cnt_q + 1 is the number of synchronized high cycles seen so far
            if (fall_s) begin
               shift_d = {shift_q[38:0], (cnt_q >= THRESH_M1)};
               idx_d   = idx_q + 6'd1;
               if (idx_q == LAST_BIT) state_d = CHECK;
               else                   state_d = BIT_LOW;
            end else if (timeout_s) begin
               state_d    = DONE;
               error_d    = 1'b1;
               err_code_d = ERR_BIT_TIMEOUT;
            end else begin
               state_d = BIT_HIGH;
            end
         end
         CHECK: begin
            state_d = DONE;
            if (checksum_ok(shift_q)) begin
               valid_d    = 1'b1;
               hum_int_d  = shift_q[39:32];
               hum_dec_d  = shift_q[31:24];
               temp_int_d = shift_q[23:16];
               temp_dec_d = shift_q[15:8];
            end else begin
               error_d    = 1'b1;
               err_code_d = ERR_CHECKSUM;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (state_q == IDLE) begin
         cnt_d = '0;
      end else if ((state_q != START_LOW) && (cnt_q >= TO_SAT)) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + 15'd1;
      end

      dht_oe_d = (state_d == START_LOW);
      busy_d   = (state_d != IDLE);
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= 6'd0;
         shift_q    <= 40'd0;
         dht_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         error_q    <= 1'b0;
         err_code_q <= ERR_NONE;
         hum_int_q  <= 8'h00;
         hum_dec_q  <= 8'h00;
         temp_int_q <= 8'h00;
         temp_dec_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         dht_oe_q   <= dht_oe_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
         hum_int_q  <= hum_int_d;
         hum_dec_q  <= hum_dec_d;
         temp_int_q <= temp_int_d;
         temp_dec_q <= temp_dec_d;
      end
   end

   assign dht_oe   = dht_oe_q;
   assign busy     = busy_q;
   assign valid    = valid_q;
   assign error    = error_q;
   assign err_code = err_code_q;
   assign hum_int  = hum_int_q;
   assign hum_dec  = hum_dec_q;
   assign temp_int = temp_int_q;
   assign temp_dec = temp_dec_q;

endmodule

// File: doc/dht11_controller.md
DHT11_CONTROLLER -- requirements
Module: dht11_controller

Interface
REQ-001 Parameter START_LOW_CYC, default 18000, host low-pulse length in clk cycles (18 ms at the 1 MHz divided clock).
REQ-002 Parameter TIMEOUT_CYC, default 200, maximum cycles any single line level may persist during a read.
REQ-003 Parameter BIT_THRESH_CYC, default 48, high-phase length at or above which a data bit is decoded as 1.
REQ-004 clk  input  1  divided system clock (1 MHz); all logic is on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle read request; sampled only in IDLE.
REQ-007 dht_in  input  1  raw sensor data line level; asynchronous to clk.
REQ-008 dht_oe  output  1  1 = pad drives the line low; 0 = release (pull-up).
REQ-009 busy  output  1  high from the accepted start until the cycle after DONE/ERROR.
REQ-010 valid  output  1  one-cycle pulse when a checksum-correct frame is presented.
REQ-011 hum_int, hum_dec, temp_int, temp_dec  output  8 each  last valid frame bytes.
REQ-012 error  output  1  one-cycle pulse on a failed read.
REQ-013 err_code  output  2  cause of the last failure: 01 no response, 10 bit timeout, 11 checksum; holds until the next error.

Function
REQ-014 dht_in is passed through a 2-flop synchronizer; the FSM uses only the synchronized level and its falling/rising edge strobes.
REQ-015 The FSM states are IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, and DONE.
REQ-016 IDLE: start=1 -> START_LOW, clear the cycle counter, bit index = 0; start while busy is ignored.
REQ-017 START_LOW: dht_oe=1 for exactly START_LOW_CYC cycles, then dht_oe=0 and go to WAIT_RESP.
REQ-018 WAIT_RESP: a synchronized falling edge -> RESP_LOW; counter reaching TIMEOUT_CYC -> error, err_code=01.
REQ-019 RESP_LOW: rising edge -> RESP_HIGH; RESP_HIGH: falling edge -> BIT_LOW; a timeout in either -> err_code=01.
REQ-020 BIT_LOW: rising edge -> BIT_HIGH with counter cleared; a timeout -> err_code=10.
REQ-021 BIT_HIGH: on a falling edge, shift in (count >= BIT_THRESH_CYC) MSB-first into a 40-bit shift register and increment the bit index.
REQ-022 BIT_HIGH exit: after a bit index of 40 -> CHECK, else -> BIT_LOW; a timeout -> err_code=10.
REQ-023 CHECK: the frame passes when (b0+b1+b2+b3) mod 256 == b4, with b0 the first byte received.
REQ-024 CHECK pass: the four output bytes are updated and valid pulses in the same cycle.
REQ-025 CHECK fail: the output bytes are held, error pulses, and err_code=11.
REQ-026 The counter saturates at TIMEOUT_CYC and resets on every state change; it is 15 bits wide so it covers START_LOW_CYC.
REQ-027 Every error path drives dht_oe=0 and passes through DONE.
REQ-028 DONE lasts one cycle, then the FSM returns to IDLE; a new start is accepted in IDLE only.
REQ-029 dht_oe=1 only in START_LOW; the line is never driven during the response or data phases.
REQ-030 If an edge and a timeout occur in the same cycle, the edge wins.

Reset
REQ-031 rst=1 forces IDLE immediately and asynchronously, together with: dht_oe=0, busy=0, valid=0, error=0, err_code=00, all data bytes 0x00, shift register 0, counter 0, bit index 0, synchronizer flops 1.
REQ-032 Reset asserted mid-read aborts the read with no valid or error pulse; the first start after release begins a fresh START_LOW.

Structure
REQ-033 A shared package dht11_pkg holds the FSM state enum, the err_code constants, and the default timing constants.
REQ-034 The synchronizer plus edge detector is a single sub-module, dht11_sync, instantiated once.
REQ-035 The block is driven by the existing 1 MHz divider output; it contains no further clock division.

Verification
REQ-036 Bench scenario: a sensor model returns humidity 0x37.00 and temperature 0x19.00 with checksum 0x50 -> valid pulse; hum_int=0x37, temp_int=0x19; dht_oe high for exactly 18000 cycles.
REQ-037 Bench scenario: the sensor stays silent after release -> error pulse 200 cycles after dht_oe falls; err_code=01; busy drops.
REQ-038 Bench scenario: the checksum byte is corrupted to 0x51 -> error with err_code=11; the outputs keep their previous values.
REQ-039 Bench scenario: the line is held high for 300 cycles at bit 17 -> error with err_code=10.
REQ-040 Bench scenario: rst pulses during bit 20 -> no pulses; IDLE; outputs 0x00; a following start completes a normal read.
REQ-041 Bench scenario: bit high phases of 47 and 48 cycles -> decoded as 0 and 1 respectively; start pulses during busy are ignored.
